// File: rtl/interval_timer_if.sv
// Start/expire handshake between the traffic FSM (master) and the interval timer (slave).
// start_timer is a 1-cycle request; expired and sec_tick are 1-cycle pulses; busy/remaining are levels.
interface interval_timer_if #(
   parameter int TIME_W = 4
);
   logic              start_timer;
   logic [TIME_W-1:0] time_value;
   logic              expired;
   logic              busy;
   logic [TIME_W-1:0] remaining;
   logic              sec_tick;

   modport master (
      output start_timer, time_value,
      input  expired, busy, remaining, sec_tick
   );

   modport slave (
      input  start_timer, time_value,
      output expired, busy, remaining, sec_tick
   );
endinterface

// File: rtl/interval_timer.sv
// Seconds countdown timer: latches time_value on start_timer, ticks every CLKS_PER_SEC clocks,
// and pulses expired once when the interval runs out. All outputs are registered.
module interval_timer #(
   parameter int CLKS_PER_SEC = 4,
   parameter int TIME_W       = 4
) (
   input  logic            clk,
   input  logic            global_reset,
   interval_timer_if.slave bus,
   output logic            o_dbg_state
);
   localparam int PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
   localparam logic [PW-1:0] LAST_PRESC = PW'(CLKS_PER_SEC - 1);

   typedef enum logic [0:0] {S_IDLE, S_COUNT} state_t;

   state_t            r_state;
   logic [PW-1:0]     r_presc;
   logic [TIME_W-1:0] r_remaining;
   logic              r_expired;
   logic              r_sec_tick;

   state_t            w_state_nxt;
   logic [PW-1:0]     w_presc_nxt;
   logic [TIME_W-1:0] w_rem_nxt;
   logic              w_exp_nxt;
   logic              w_tick_nxt;

   always_ff @(posedge clk) begin
      if (global_reset) begin
         r_state     <= S_IDLE;
         r_presc     <= '0;
         r_remaining <= '0;
         r_expired   <= 1'b0;
         r_sec_tick  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_presc     <= w_presc_nxt;
         r_remaining <= w_rem_nxt;
         r_expired   <= w_exp_nxt;
         r_sec_tick  <= w_tick_nxt;
      end
   end

   // A start request preempts everything, including a final tick on the same edge.
   always_comb begin
      w_state_nxt = r_state;
      w_presc_nxt = r_presc;
      w_rem_nxt   = r_remaining;
      w_exp_nxt   = 1'b0;
      w_tick_nxt  = 1'b0;
      if (bus.start_timer) begin
         w_presc_nxt = '0;
         w_rem_nxt   = bus.time_value;
         if (bus.time_value != '0) begin
            w_state_nxt = S_COUNT;
         end else begin
            w_state_nxt = S_IDLE;
            w_exp_nxt   = 1'b1;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               w_presc_nxt = '0;
            end
            S_COUNT: begin
               if (r_presc == LAST_PRESC) begin
                  w_presc_nxt = '0;
                  w_tick_nxt  = 1'b1;
                  w_rem_nxt   = r_remaining - TIME_W'(1);
                  if (r_remaining == TIME_W'(1)) begin
                     w_exp_nxt   = 1'b1;
                     w_state_nxt = S_IDLE;
                  end
               end else begin
                  w_presc_nxt = r_presc + PW'(1);
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   assign bus.expired   = r_expired;
   assign bus.busy      = (r_state == S_COUNT);
   assign bus.remaining = r_remaining;
   assign bus.sec_tick  = r_sec_tick;
   assign o_dbg_state   = (r_state == S_COUNT);
endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer with CLKS_PER_SEC=4: a vector table of single cycles,
// then hand-written multi-cycle sequences for countdown, restart, reset and final-tick cases.
module tb_interval_timer;
   localparam int CPS = 4;
   localparam int TW  = 4;

   logic clk;
   logic rst;
   logic dbg_state;
   int   n_vec;
   int   n_err;

   interval_timer_if #(.TIME_W(TW)) bus ();

   interval_timer #(.CLKS_PER_SEC(CPS), .TIME_W(TW)) dut (
      .clk          (clk),
      .global_reset (rst),
      .bus          (bus.slave),
      .o_dbg_state  (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          rst;
      logic          start;
      logic [TW-1:0] tv;
      logic          e_exp;
      logic          e_busy;
      logic [TW-1:0] e_rem;
      logic          e_tick;
   } vec_t;

   vec_t vt[12];

   task automatic chk1(input string name, input logic act, input logic exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s vec=%0d got=%b want=%b", name, n_vec, act, exp);
      end
   endtask

   // One clock: drive inputs, take the edge, sample 1 time unit later and compare.
   task automatic step(input logic r, input logic st, input logic [TW-1:0] tv,
                       input logic e_exp, input logic e_busy, input logic [TW-1:0] e_rem,
                       input logic e_tick);
      rst             = r;
      bus.start_timer = st;
      bus.time_value  = tv;
      @(posedge clk);
      #1;
      n_vec++;
      chk1("expired", bus.expired, e_exp);
      chk1("busy", bus.busy, e_busy);
      chk1("sec_tick", bus.sec_tick, e_tick);
      chk1("dbg_state", dbg_state, e_busy);
      if (bus.remaining !== e_rem) begin
         n_err++;
         $display("FAIL remaining vec=%0d got=%0d want=%0d", n_vec, bus.remaining, e_rem);
      end
   endtask

   // Cycles 1..n after a start with interval t (start edge is cycle 0).
   task automatic count_seq(input int t, input int n, input logic [TW-1:0] tv_noise);
      for (int c = 1; c <= n; c++) begin
         step(1'b0, 1'b0, tv_noise,
              (c == t * CPS), (c < t * CPS),
              TW'(t - c / CPS), (c % CPS == 0));
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b1;
      bus.start_timer = 1'b0;
      bus.time_value  = '0;

      //        rst   start tv     exp   busy  rem    tick
      vt[0]  = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0};
      vt[1]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0};
      vt[2]  = '{1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0};
      vt[3]  = '{1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 4'd0, 1'b0};
      vt[4]  = '{1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 4'd1, 1'b0};
      vt[5]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0};
      vt[6]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0};
      vt[7]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0};
      vt[8]  = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1};
      vt[9]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0};
      vt[10] = '{1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0};
      vt[11] = '{1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0};

      for (int i = 0; i < 12; i++) begin
         step(vt[i].rst, vt[i].start, vt[i].tv,
              vt[i].e_exp, vt[i].e_busy, vt[i].e_rem, vt[i].e_tick);
      end

      // Full T=6 countdown
      step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
      step(1'b0, 1'b1, 4'd6, 1'b0, 1'b1, 4'd6, 1'b0);
      count_seq(6, 24, 4'd6);
      idle(2);

      // T=0 start: immediate expired, never busy
      step(1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);
      idle(2);

      // Restart T=9 -> T=2 at remaining=5
      step(1'b0, 1'b1, 4'd9, 1'b0, 1'b1, 4'd9, 1'b0);
      count_seq(9, 16, 4'd9);
      step(1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 4'd2, 1'b0);
      count_seq(2, 8, 4'd0);
      idle(2);

      // time_value changes mid-count are ignored
      step(1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 4'd3, 1'b0);
      count_seq(3, 12, 4'd12);
      idle(2);

      // Reset at remaining=3 (start held high too), then T=1
      step(1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 4'd5, 1'b0);
      count_seq(5, 8, 4'd5);
      step(1'b1, 1'b1, 4'd7, 1'b0, 1'b0, 4'd0, 1'b0);
      idle(12);
      step(1'b0, 1'b1, 4'd1, 1'b0, 1'b1, 4'd1, 1'b0);
      count_seq(1, 4, 4'd1);
      idle(2);

      // Restart on the final-tick edge: no expired, no tick
      step(1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 4'd2, 1'b0);
      count_seq(2, 7, 4'd2);
      step(1'b0, 1'b1, 4'd4, 1'b0, 1'b1, 4'd4, 1'b0);
      count_seq(4, 16, 4'd4);
      idle(2);

      // Maximum interval
      step(1'b0, 1'b1, 4'd15, 1'b0, 1'b1, 4'd15, 1'b0);
      count_seq(15, 60, 4'd0);
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
